// File: rtl/cnt_bcd_multi.sv
// Multi-digit packed-BCD up/down counter with programmable limit, wrap/saturate
// terminal modes, synchronous clear, validated parallel load and pulse flags.

module cnt_bcd_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module cnt_bcd_multi #(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] LIMIT     = 'h99,
    parameter logic [4*DIGITS-1:0] RESET_VAL = 'h05
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_en,
    input  logic                cnt_type,
    input  logic                sat,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_data,
    output logic [4*DIGITS-1:0] cnt_data,
    output logic                wrap,
    output logic                sat_hit,
    output logic                load_err,
    output logic                at_max,
    output logic                at_min
);
    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $fatal(1, "cnt_bcd_multi: DIGITS must be 1..8");
    end
    if (RESET_VAL > LIMIT) begin : g_bad_reset
        $fatal(1, "cnt_bcd_multi: RESET_VAL exceeds LIMIT");
    end

    logic [DIGITS:0]   carry;
    logic [W-1:0]      step;
    logic [DIGITS-1:0] nib_ok;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (LIMIT[4*i +: 4] > 4'd9) begin : g_bad_limit
            $fatal(1, "cnt_bcd_multi: LIMIT is not valid BCD");
        end
        if (RESET_VAL[4*i +: 4] > 4'd9) begin : g_bad_rval
            $fatal(1, "cnt_bcd_multi: RESET_VAL is not valid BCD");
        end

        cnt_bcd_digit u_dig (
            .d    (cnt_data[4*i +: 4]),
            .up   (cnt_type),
            .cin  (carry[i]),
            .q    (step[4*i +: 4]),
            .cout (carry[i+1])
        );

        assign nib_ok[i] = (load_data[4*i +: 4] <= 4'd9);
    end

    // For valid BCD, binary order of the packed word equals decimal order.
    logic load_ok;
    assign load_ok = (&nib_ok) && (load_data <= LIMIT);

    // A borrow out of the top digit means the count was already 0.
    logic at_end;
    assign at_end = cnt_type ? (cnt_data == LIMIT) : carry[DIGITS];

    logic [W-1:0] nxt;
    logic         wrap_n, sat_n, lerr_n;

    always_comb begin
        nxt    = cnt_data;
        wrap_n = 1'b0;
        sat_n  = 1'b0;
        lerr_n = 1'b0;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            if (load_ok) nxt = load_data;
            else         lerr_n = 1'b1;
        end else if (cnt_en) begin
            if (!at_end) begin
                nxt = step;
            end else if (sat) begin
                sat_n = 1'b1;
            end else begin
                nxt    = cnt_type ? '0 : LIMIT;
                wrap_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_data <= RESET_VAL;
            wrap     <= 1'b0;
            sat_hit  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt_data <= nxt;
            wrap     <= wrap_n;
            sat_hit  <= sat_n;
            load_err <= lerr_n;
        end
    end

    assign at_max = (cnt_data == LIMIT);
    assign at_min = (cnt_data == '0);
endmodule

// File: doc/cnt_bcd_multi.md
# cnt_bcd_multi

Parametrised multi-digit BCD up/down counter, the successor to the single-digit 0–9 up/down counter. It provides DIGITS cascaded decimal digits that count up or down within a programmable upper limit. Terminal behaviour is selectable at run time: wrap or saturate. It also supports synchronous clear, parallel load with validation, and registered event flags. It serves display, timer and event-count datapaths that need more than one decimal digit.

## Interface
- DIGITS, 2, number of BCD digits (1–8); counter width W = 4*DIGITS
- LIMIT, 'h99, packed-BCD upper limit; every nibble must be ≤ 9; range is 0..LIMIT
- RESET_VAL, 'h05, packed-BCD value loaded on reset; must be ≤ LIMIT and valid BCD
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cnt_en  in  1  count enable for the current cycle
- cnt_type  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at the ends, 0 = wrap around
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_data  in  W  packed-BCD load value
- cnt_data  out  W  packed-BCD count (registered)
- wrap  out  1  one-cycle pulse: the count wrapped on the previous edge
- sat_hit  out  1  one-cycle pulse: a count was blocked by saturation
- load_err  out  1  one-cycle pulse: a load was rejected
- at_max  out  1  cnt_data == LIMIT (decoded from the register only)
- at_min  out  1  cnt_data == 0 (decoded from the register only)

## Operation
- Priority per clock edge, highest first: rst, then clr, then load, then cnt_en.
- rst: cnt_data = RESET_VAL. wrap, sat_hit and load_err = 0.
- clr: cnt_data = 0. The flags pulse 0. load and cnt_en are ignored that cycle.
- load: accepted only if every nibble of load_data is ≤ 9 and load_data ≤ LIMIT (decimal compare).
  - Accepted: cnt_data = load_data.
  - Rejected: cnt_data holds and load_err pulses.
  - cnt_en is ignored in the load cycle either way.
- Count up (cnt_en=1, cnt_type=1):
  - Below LIMIT: BCD increment. Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. The full ripple resolves in the same cycle.
  - At LIMIT, sat=0: next value is 0 and wrap pulses.
  - At LIMIT, sat=1: value holds and sat_hit pulses.
- Count down (cnt_en=1, cnt_type=0):
  - Above 0: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit.
  - At 0, sat=0: next value is LIMIT and wrap pulses.
  - At 0, sat=1: value holds and sat_hit pulses.
- cnt_en=0 with no clr or load: hold, and all pulses are 0.
- cnt_data never leaves the legal set {valid BCD, ≤ LIMIT} after reset.
- Parameter legality (LIMIT and RESET_VAL valid BCD, RESET_VAL ≤ LIMIT, DIGITS 1–8) is checked at elaboration. A violation is a fatal error.

## Timing
- All outputs except at_max and at_min are flops updated on the rising edge of clk.
- at_max and at_min are combinational decodes of cnt_data only, with no input-to-output path.
- Latency: one cycle from any command (cnt_en, load, clr) to the new cnt_data and flags.
- wrap, sat_hit and load_err are high for exactly the one cycle after the triggering edge. Back-to-back triggering events give back-to-back pulses.
- cnt_type and sat are sampled on every edge. Changing direction mid-count takes effect on the next edge with no dead cycle.
- rst asserted mid-operation forces the reset values immediately and asynchronously. On release, counting resumes on the first rising edge at which rst is low.
- Simultaneous events resolve by the stated priority:
  - clr + load: clear wins and load_err is not raised.
  - load + cnt_en: load wins.

## Test plan
- Reset and hold: DIGITS=2, LIMIT='h99. Pulse rst -> cnt_data='h05, all flags 0. Hold cnt_en=0 for 10 cycles -> cnt_data stays 'h05.
- Up-count wrap: load 'h97, then up for 3 cycles -> 'h98, 'h99, 'h00. wrap is high only in the cycle showing 'h00. Carry from 'h09 -> 'h10 is also checked.
- Down-count with LIMIT='h59 (wrap mode): from 'h10 -> 'h09 (borrow). From 'h00 -> 'h59 and wrap pulses. at_min is high while the value is 'h00.
- Saturate mode: sat=1 at 'h99 counting up -> holds 'h99, sat_hit pulses each enabled cycle. Counting down at 'h00 -> holds 'h00.
- Load validation (LIMIT='h59): load 'h3A -> rejected, load_err pulses, value unchanged. Load 'h60 -> rejected. Load 'h42 with cnt_en=1 -> cnt_data='h42, no count that cycle.
- Priority and async reset: clr+load+cnt_en in the same cycle -> 'h00, no flags. Assert rst between edges mid-count -> cnt_data='h05 immediately, without waiting for a clock edge.
